// File: rtl/marvin_utils_pkg.sv
// Shared types and helpers for the MARVIN utils sector.
package marvin_utils_pkg;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } timer_state_t;

  // Counter width able to hold 0..t, never narrower than one bit.
  function automatic int unsigned cw_for(input int unsigned t);
    int unsigned w;
    w = $clog2(t + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Programmable down-counter with valid/ready load, one-shot or
// auto-reload operation, pause and abort. Expiry is a one-cycle pulse.
module countdown_timer
  import marvin_utils_pkg::*;
#(
  parameter int unsigned T = 255,
  localparam int unsigned CW = cw_for(T)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [CW-1:0] load_value,
  input  logic          load_reload,
  input  logic          pause,
  input  logic          abort,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          expired
);

  localparam logic [CW-1:0] TMAX = CW'(T);

  timer_state_t  r_state;
  timer_state_t  w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_reload_val;
  logic          r_reload_en;
  logic          r_busy;
  logic          r_expired;
  logic          w_accept;
  logic [CW-1:0] w_clamped;

  // Next-state decode, load handshake and clamped load value.
  always_comb begin
    w_state_next = r_state;
    load_ready   = (r_state == TMR_IDLE) && !abort;
    w_accept     = load_valid && load_ready;
    w_clamped    = (load_value > TMAX) ? TMAX : load_value;
    case (r_state)
      TMR_IDLE: begin
        if (w_accept) w_state_next = TMR_RUN;
      end
      TMR_RUN: begin
        if (abort)
          w_state_next = TMR_IDLE;
        else if (!pause && (r_count == '0) && !r_reload_en)
          w_state_next = TMR_IDLE;
      end
      default: w_state_next = TMR_IDLE;
    endcase
  end

  // State, count, reload registers and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= TMR_IDLE;
      r_count      <= '0;
      r_reload_val <= '0;
      r_reload_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_expired    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_busy    <= (w_state_next == TMR_RUN);
      r_expired <= 1'b0;
      case (r_state)
        TMR_IDLE: begin
          if (w_accept) begin
            r_count      <= w_clamped;
            r_reload_val <= w_clamped;
            r_reload_en  <= load_reload;
          end
        end
        TMR_RUN: begin
          // Abort wins over pause and over an expiry due this cycle.
          if (abort) begin
            r_count     <= '0;
            r_reload_en <= 1'b0;
          end else if (!pause) begin
            if (r_count != '0) begin
              r_count <= r_count - 1'b1;
            end else begin
              r_expired <= 1'b1;
              if (r_reload_en) r_count <= r_reload_val;
            end
          end
        end
        default: begin
          r_count     <= '0;
          r_reload_en <= 1'b0;
        end
      endcase
    end
  end

  assign count   = r_count;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed bench for countdown_timer at T=255, T=10 and T=1,
// with a per-instance behavioural reference model.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       lvld;
  logic [7:0] lv;
  logic       lr;
  logic       pause;
  logic       abort;

  logic       rdy_a, busy_a, exp_a;
  logic [7:0] cnt_a;
  logic       rdy_b, busy_b, exp_b;
  logic [3:0] cnt_b;
  logic       rdy_c, busy_c, exp_c;
  logic [0:0] cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance.
  int unsigned tmax[3] = '{255, 10, 1};
  int unsigned vmask[3] = '{255, 15, 1};
  int unsigned m_cnt[3];
  int unsigned m_rv[3];
  bit          m_run[3];
  bit          m_ren[3];
  bit          m_exp[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  countdown_timer #(.T(255)) u_a (
    .clk(clk), .rst(rst), .load_valid(lvld), .load_ready(rdy_a),
    .load_value(lv), .load_reload(lr), .pause(pause), .abort(abort),
    .count(cnt_a), .busy(busy_a), .expired(exp_a)
  );

  countdown_timer #(.T(10)) u_b (
    .clk(clk), .rst(rst), .load_valid(lvld), .load_ready(rdy_b),
    .load_value(lv[3:0]), .load_reload(lr), .pause(pause), .abort(abort),
    .count(cnt_b), .busy(busy_b), .expired(exp_b)
  );

  countdown_timer #(.T(1)) u_c (
    .clk(clk), .rst(rst), .load_valid(lvld), .load_ready(rdy_c),
    .load_value(lv[0:0]), .load_reload(lr), .pause(pause), .abort(abort),
    .count(cnt_c), .busy(busy_c), .expired(exp_c)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One clock of the timer rules applied to every modelled instance.
  task automatic model_step();
    int unsigned v;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_run[k] = 0; m_cnt[k] = 0; m_exp[k] = 0; m_ren[k] = 0; m_rv[k] = 0;
      end else begin
        m_exp[k] = 0;
        if (!m_run[k]) begin
          if (lvld && !abort) begin
            v = int'(lv) & vmask[k];
            if (v > tmax[k]) v = tmax[k];
            m_cnt[k] = v; m_rv[k] = v; m_ren[k] = lr; m_run[k] = 1;
          end
        end else if (abort) begin
          m_run[k] = 0; m_cnt[k] = 0; m_ren[k] = 0;
        end else if (!pause) begin
          if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
          else begin
            m_exp[k] = 1;
            if (m_ren[k]) m_cnt[k] = m_rv[k];
            else m_run[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("a.count", int'(cnt_a), int'(m_cnt[0]));
    check("a.busy", int'(busy_a), int'(m_run[0]));
    check("a.expired", int'(exp_a), int'(m_exp[0]));
    check("a.ready", int'(rdy_a), int'(!m_run[0] && !abort));
    check("b.count", int'(cnt_b), int'(m_cnt[1]));
    check("b.busy", int'(busy_b), int'(m_run[1]));
    check("b.expired", int'(exp_b), int'(m_exp[1]));
    check("b.ready", int'(rdy_b), int'(!m_run[1] && !abort));
    check("c.count", int'(cnt_c), int'(m_cnt[2]));
    check("c.busy", int'(busy_c), int'(m_run[2]));
    check("c.expired", int'(exp_c), int'(m_exp[2]));
    check("c.ready", int'(rdy_c), int'(!m_run[2] && !abort));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic vld, input logic [7:0] val,
                       input logic rl, input logic p, input logic ab);
    rst = r; lvld = vld; lv = val; lr = rl; pause = p; abort = ab;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'd0, 0, 0, 0);
  endtask

  initial begin
    int last;
    rst = 1; lvld = 0; lv = 0; lr = 0; pause = 0; abort = 0;
    drive(1, 0, 8'd0, 0, 0, 0);
    drive(1, 0, 8'd0, 0, 0, 0);

    // One-shot load of 5
    drive(0, 1, 8'd5, 0, 0, 0);
    check("oneshot.load", int'(cnt_a), 5);
    idle(7);
    check("oneshot.ready", int'(rdy_a), 1);

    // Auto-reload of 3, with an ignored load attempt mid-run
    drive(0, 1, 8'd3, 1, 0, 0);
    last = -1;
    for (int i = 0; i < 20; i++) begin
      drive(0, (i == 6), 8'd9, 0, 0, 0);
      if (exp_a) begin
        if (last >= 0) check("reload.gap", i - last, 4);
        last = i;
      end
    end
    drive(0, 0, 8'd0, 0, 0, 1);

    // Reset in the middle of a run at count 7
    drive(0, 1, 8'd10, 0, 0, 0);
    idle(3);
    check("rst.pre", int'(cnt_a), 7);
    drive(1, 0, 8'd0, 0, 0, 0);
    drive(1, 0, 8'd0, 0, 0, 0);
    check("rst.count", int'(cnt_a), 0);
    idle(1);

    // Clamp to T=10, pause at 6, then pause held at 0
    drive(0, 1, 8'd15, 0, 0, 0);
    check("clamp", int'(cnt_b), 10);
    idle(4);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'd0, 0, 1, 0);
    check("pause.hold", int'(cnt_b), 6);
    idle(6);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'd0, 0, 1, 0);
    idle(3);
    idle(10);

    // Abort exactly when expiry is due
    drive(0, 1, 8'd2, 0, 0, 0);
    idle(2);
    drive(0, 0, 8'd0, 0, 0, 1);
    check("abort.noexp", int'(exp_a), 0);
    // Abort with a load in idle
    drive(0, 1, 8'd4, 1, 0, 1);
    check("abort.noload", int'(busy_a), 0);
    idle(2);

    // Edge loads: 0 one-shot, 0 reload, 1 reload (T=1 expires every 2)
    drive(0, 1, 8'd0, 0, 0, 0);
    idle(2);
    drive(0, 1, 8'd0, 1, 0, 0);
    idle(5);
    drive(0, 0, 8'd0, 0, 0, 1);
    drive(0, 1, 8'd1, 1, 0, 0);
    idle(8);
    drive(0, 0, 8'd0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(2) == 0),
            8'($urandom), 1'($urandom), ($urandom_range(3) == 0),
            ($urandom_range(15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
